// File: rtl/dm_responder.sv
// Data-memory responder: single outstanding word read/write over req/ack, with a programmable
// number of wait states, byte-lane writes, illegal-access flagging and registered read data.
module dm_responder #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned WAIT_CYC = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [3:0]  i_be,
    input  logic [31:0] i_wdata,
    output logic        o_ack,
    output logic [31:0] o_rdata,
    output logic        o_err,
    output logic        o_busy
);

    localparam int unsigned Depth = 1 << ADDR_W;
    localparam int unsigned CntW  = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              commit;

    logic [31:0]       mem [Depth];

    logic              acc_we;
    logic [31:0]       acc_addr;
    logic [3:0]        acc_be;
    logic [31:0]       acc_wdata;
    logic [ADDR_W-1:0] acc_idx;
    logic              acc_err;

    // With zero wait states the access commits on the accepting edge, so use the live inputs.
    always_comb begin
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_be    = be_q;
        acc_wdata = wdata_q;
        if (state_q == StIdle) begin
            acc_we    = i_we;
            acc_addr  = i_addr;
            acc_be    = i_be;
            acc_wdata = i_wdata;
        end
        acc_idx = acc_addr[ADDR_W+1:2];
        acc_err = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (ADDR_W + 2)) != 32'd0);
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        commit  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_req) begin
                    we_d    = i_we;
                    addr_d  = i_addr;
                    be_d    = i_be;
                    wdata_d = i_wdata;
                    if (WAIT_CYC == 0) begin
                        state_d = StResp;
                        commit  = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CntW'(WAIT_CYC);
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StResp;
                    commit  = 1'b1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Response capture on the edge entering RESP
    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (commit) begin
            err_d   = acc_err;
            rdata_d = (acc_err || acc_we) ? 32'd0 : mem[acc_idx];
        end
    end

    // Memory is deliberately not reset; reset only suppresses a write on a coincident edge.
    always_ff @(posedge clk) begin
        if (commit && reset && acc_we && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_be[b]) begin
                    mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
    end

    // Outputs
    always_comb begin
        o_ack  = (state_q == StResp);
        o_err  = (state_q == StResp) && err_q;
        o_busy = (state_q != StIdle);
    end

    assign o_rdata = rdata_q;

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: one instance with two wait states, one with none.
module tb_dm_responder;

    typedef struct {
        int unsigned cyc;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    // Two-wait-state instance
    logic        req2 = 1'b0, we2 = 1'b0;
    logic [31:0] addr2 = '0, wdata2 = '0;
    logic [3:0]  be2 = '0;
    logic        ack2, err2, busy2;
    logic [31:0] rdata2;

    // Zero-wait-state instance
    logic        req0 = 1'b0, we0 = 1'b0;
    logic [31:0] addr0 = '0, wdata0 = '0;
    logic [3:0]  be0 = '0;
    logic        ack0, err0, busy0;
    logic [31:0] rdata0;

    exp_t q2[$];
    exp_t q0[$];

    dm_responder #(.ADDR_W(10), .WAIT_CYC(2)) dut (
        .clk(clk), .reset(reset), .i_req(req2), .i_we(we2), .i_addr(addr2), .i_be(be2),
        .i_wdata(wdata2), .o_ack(ack2), .o_rdata(rdata2), .o_err(err2), .o_busy(busy2)
    );

    dm_responder #(.ADDR_W(10), .WAIT_CYC(0)) dut0 (
        .clk(clk), .reset(reset), .i_req(req0), .i_we(we0), .i_addr(addr0), .i_be(be0),
        .i_wdata(wdata0), .o_ack(ack0), .o_rdata(rdata0), .o_err(err0), .o_busy(busy0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor_pop(input int sel, input logic err, input logic [31:0] rdata);
        exp_t e;
        if (sel == 2 ? (q2.size() == 0) : (q0.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack_dut%0d: ack seen at cycle %0d, none expected", sel, cyc);
        end else begin
            e = (sel == 2) ? q2.pop_front() : q0.pop_front();
            check($sformatf("ack_cycle_dut%0d", sel), cyc, e.cyc);
            check($sformatf("err_dut%0d", sel), {31'd0, err}, {31'd0, e.err});
            check($sformatf("rdata_dut%0d", sel), rdata, e.rdata);
        end
    endtask

    always @(negedge clk) begin
        if (ack2) monitor_pop(2, err2, rdata2);
        if (ack0) monitor_pop(0, err0, rdata0);
    end

    // Issue one handshaked access (called just after a negedge) and wait for its ack.
    task automatic access(input int sel, input logic we, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wdata,
                          input logic exp_err, input logic [31:0] exp_rdata);
        exp_t e;
        bit   seen = 0;
        e.cyc   = cyc + ((sel == 2) ? 3 : 1);
        e.err   = exp_err;
        e.rdata = exp_rdata;
        if (sel == 2) begin
            q2.push_back(e);
            we2 = we; addr2 = addr; be2 = be; wdata2 = wdata; req2 = 1'b1;
        end else begin
            q0.push_back(e);
            we0 = we; addr0 = addr; be0 = be; wdata0 = wdata; req0 = 1'b1;
        end
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if ((sel == 2) ? ack2 : ack0) seen = 1;
        end
        req2 = 1'b0;
        req0 = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout_dut%0d: no ack within 20 cycles, expected one", sel);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_ack", {31'd0, ack2}, 32'd0);
        check("reset_err", {31'd0, err2}, 32'd0);
        check("reset_busy", {31'd0, busy2}, 32'd0);
        check("reset_rdata", rdata2, 32'd0);
        check("reset_busy0", {31'd0, busy0}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Full write then read
        access(2, 1'b1, 32'h10, 4'b1111, 32'h12345678, 1'b0, 32'h0);
        access(2, 1'b0, 32'h10, 4'b0000, 32'h0, 1'b0, 32'h12345678);
        // Partial lanes
        access(2, 1'b1, 32'h10, 4'b0101, 32'hAABBCCDD, 1'b0, 32'h0);
        access(2, 1'b0, 32'h10, 4'b1111, 32'h0, 1'b0, 32'h12BB56DD);
        // Misaligned read and write
        access(2, 1'b0, 32'h13, 4'b1111, 32'h0, 1'b1, 32'h0);
        access(2, 1'b1, 32'h13, 4'b1111, 32'hDEADBEEF, 1'b1, 32'h0);
        access(2, 1'b0, 32'h10, 4'b1111, 32'h0, 1'b0, 32'h12BB56DD);
        // be=0000 write is a no-op
        access(2, 1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, 1'b0, 32'h0);
        access(2, 1'b0, 32'h10, 4'b1111, 32'h0, 1'b0, 32'h12BB56DD);
        // Range boundary
        access(2, 1'b0, 32'h1000, 4'b1111, 32'h0, 1'b1, 32'h0);
        access(2, 1'b1, 32'hFFC, 4'b1111, 32'hCAFEF00D, 1'b0, 32'h0);
        access(2, 1'b0, 32'hFFC, 4'b1111, 32'h0, 1'b0, 32'hCAFEF00D);

        // Reset during WAIT aborts the write
        access(2, 1'b1, 32'h20, 4'b1111, 32'h11112222, 1'b0, 32'h0);
        access(2, 1'b0, 32'h20, 4'b1111, 32'h0, 1'b0, 32'h11112222);
        we2 = 1'b1; addr2 = 32'h20; be2 = 4'b1111; wdata2 = 32'hFFFFFFFF; req2 = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy_before", {31'd0, busy2}, 32'd1);
        reset = 1'b0;
        #1;
        check("abort_busy_after", {31'd0, busy2}, 32'd0);
        check("abort_ack", {31'd0, ack2}, 32'd0);
        check("abort_rdata", rdata2, 32'd0);
        req2 = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        access(2, 1'b0, 32'h20, 4'b1111, 32'h0, 1'b0, 32'h11112222);

        // Zero wait states: seed a word, then hold req across three reads
        access(0, 1'b1, 32'h40, 4'b1111, 32'h0BADBEEF, 1'b0, 32'h0);
        begin
            exp_t e;
            e.err   = 1'b0;
            e.rdata = 32'h0BADBEEF;
            for (int k = 0; k < 3; k++) begin
                e.cyc = cyc + 1 + 2 * k;
                q0.push_back(e);
            end
        end
        we0 = 1'b0; addr0 = 32'h40; be0 = 4'b1111; req0 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("b2b_busy_%0d", i), {31'd0, busy0}, (i % 2 == 0) ? 32'd1 : 32'd0);
            if (i == 4) req0 = 1'b0;
        end

        repeat (4) @(negedge clk);
        check("q2_drained", q2.size(), 32'd0);
        check("q0_drained", q0.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
